i2c_eeprom_slave: RTL and testbench
===================================

# i2c_eeprom_slave

Synthesizable I2C slave model of the EEPROM used by the simulation testbench. It sits on the far side of the open-drain bus from the EEPROM controller and answers the controller's transactions: a two-byte word address, then page-wrapped multi-byte writes or sequential reads. It backs a 2 KiB byte array and exposes a debug read port so the bench can check memory contents directly.

## Interface
- SLAVE_ADDR, 7'h50, 7-bit device address this slave acknowledges
- PAGE_BYTES, 16, write page size in bytes; power of two, 2 to 256
- TWR_CYCLES, 0, clk cycles of internal write time after a write STOP; 0 disables it
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- scl_i  in  1  bus SCL level
- sda_i  in  1  bus SDA level
- sda_o  out  1  constant 0 (open-drain)
- sda_oe  out  1  1 = pull SDA low, 0 = release
- busy  out  1  internal write cycle in progress
- dbg_addr  in  11  debug read address
- dbg_data  out  8  mem[dbg_addr], registered, 1-cycle latency

## Operation
- scl_i and sda_i pass through 2-flop synchronizers. Edges are detected on the synchronized values.
- START: SDA falls while SCL is high. Valid in any state, including repeated START. Goes to DEV_ADDR and clears the bit counter.
- STOP: SDA rises while SCL is high. Valid in any state. Goes to IDLE and releases SDA. If any data byte was written since the last START, busy is set for TWR_CYCLES.
- Sampling and driving:
  - Data bits are sampled on the SCL rising edge, MSB first.
  - sda_oe changes only on the SCL falling edge, except at STOP, START, and reset.
- States and transitions:
  - IDLE: wait for START.
  - DEV_ADDR: shift in 8 bits, then go to ACK_DEV.
  - ACK_DEV:
    - ACK if addr[7:1] == SLAVE_ADDR and busy == 0. Otherwise NACK and go to IDLE.
    - If the R/W bit is 0, go to ADDR_H.
    - If the R/W bit is 1, go to RD_DATA and load the shift register from mem[ptr].
  - ADDR_H: shift in 8 bits, ACK, then go to ADDR_L.
  - ADDR_L: shift in 8 bits, ACK, then go to WR_DATA.
    - ptr = {addr_h[2:0], addr_l}. addr_h[7:3] is ignored.
  - WR_DATA: shift in 8 bits, then ACK.
    - mem[ptr] is written on the 8th rising edge.
    - ptr[log2(PAGE_BYTES)-1:0] increments and wraps within the page. Upper ptr bits are unchanged.
    - Return to WR_DATA.
  - RD_DATA: drive bits MSB first (sda_oe = ~bit).
    - After the 8th bit, release SDA and go to RD_ACK.
    - ptr increments modulo 2048.
  - RD_ACK: sample the master ACK on the SCL rising edge.
    - ACK (SDA low): load mem[ptr] and go to RD_DATA.
    - NACK: go to IDLE and stay released.
- The pointer persists across transactions and resets to 0. A repeated START after ADDR_L gives a random read from the new ptr.
- Memory contents are not reset. Simulation initializes them to 8'hFF.

## Timing
- Reset values: sda_oe = 0, sda_o = 0, busy = 0, dbg_data = 0, state = IDLE, ptr = 0, bit counter = 0.
- Reset mid-transfer releases SDA on the next cycle. The bus is ignored until the next START.
- Edge detection lags the pins by 2 clk. SCL high and low phases must each be at least 4 clk.
- ACK/data drive: sda_oe updates on the clk after the synchronized SCL fall. It is held through the full SCL high phase and changes only at the next SCL fall.
- ACK release: SDA is released on the SCL fall that ends the ACK bit.
- Memory write: takes effect on the clk after the 8th synchronized SCL rise. It is visible on dbg_data 2 clk after that when dbg_addr matches.
- busy: asserts the clk after the STOP is detected and lasts exactly TWR_CYCLES clk.
- START and STOP during busy: START is still detected, and the device address is NACKed (ACK polling). A write STOP while busy does not restart the timer.
- SDA change while SCL is high: with SCL high, any synchronized SDA change is treated as START or STOP, never as data. A START/STOP edge on the same clk as an SCL edge is handled as START/STOP.

## Test plan
- Write 0xA5, 0x3C at 0x123 (0xA0, 0x01, 0x23, 0xA5, 0x3C, STOP) -> all 5 bytes ACKed; dbg_data shows 0xA5 at 0x123 and 0x3C at 0x124.
- Page wrap, PAGE_BYTES = 16: write 3 bytes 0x11/0x22/0x33 starting at 0x00E -> mem[0x00E] = 0x11, mem[0x00F] = 0x22, mem[0x000] = 0x33; mem[0x010] is unchanged (0xFF).
- Random read: 0xA0, 0x01, 0x23, repeated START, 0xA1, then read 2 bytes with ACK then NACK, STOP -> returns 0xA5 then 0x3C; ptr = 0x125; SDA released after the NACK.
- Read wrap: set ptr to 0x7FF, then sequential read of 2 bytes -> mem[0x7FF] then mem[0x000].
- Address mismatch: 0xA2 -> NACK (SDA stays released); later bytes are ignored until the next START; memory is unchanged.
- TWR_CYCLES = 100: write a byte and STOP, then poll 0xA0 at 20 clk -> NACK; after busy falls (100 clk) -> ACK. Also assert rst mid-read -> sda_oe = 0 the next cycle.

Source files
------------

// File: rtl/i2c_eeprom_slave.sv
// i2c_eeprom_slave: I2C slave model of a 2 KiB EEPROM with page writes, sequential reads and a debug read port
module i2c_eeprom_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int PAGE_BYTES = 16,
  parameter int TWR_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_o,
  output logic        sda_oe,
  output logic        busy,
  input  logic [10:0] dbg_addr,
  output logic [7:0]  dbg_data
);
  localparam int PW = $clog2(PAGE_BYTES);
  typedef enum logic [3:0] {
    IDLE, DEV_ADDR, ACK_DEV, ADDR_H, ACK_H, ADDR_L, ACK_L, WR_DATA, ACK_WR, RD_DATA, RD_ACK
  } state_t;
  state_t      state;
  logic [1:0]  scl_sy, sda_sy;
  logic        scl_q, sda_q, scl_hi, start, stop, scl_rise, scl_fall, dev_match, we, wrote;
  logic [3:0]  cnt;
  logic [7:0]  sr, rd, rx_byte;
  logic [2:0]  addr_h;
  logic [10:0] ptr;
  logic [31:0] twr;
  logic [7:0]  mem_n [0:2047];
  assign sda_o = 1'b0;
  // Bus event decode; any SDA change with SCL high on either side of the clk is START/STOP, never data
  always_comb begin
    scl_hi = scl_sy[1] | scl_q;
    start = scl_hi & sda_q & ~sda_sy[1];
    stop = scl_hi & ~sda_q & sda_sy[1];
    scl_rise = scl_sy[1] & ~scl_q & ~start & ~stop;
    scl_fall = ~scl_sy[1] & scl_q & ~start & ~stop;
    rx_byte = {sr[6:0], sda_sy[1]};
    rd = ~mem_n[ptr];
    dev_match = (sr[7:1] == SLAVE_ADDR) & ~busy;
    we = ~rst & scl_rise & (state == WR_DATA) & (cnt == 4'd7);
  end
  // Byte array, held inverted so zero-initialised storage reads back as erased 0xFF
  always_ff @(posedge clk)
    if (we) mem_n[ptr] <= ~rx_byte;
  // Synchronizers, protocol FSM, pointer, write-cycle timer and debug read register
  always_ff @(posedge clk)
    if (rst) begin
      scl_sy <= 2'b11;
      sda_sy <= 2'b11;
      scl_q <= 1'b1;
      sda_q <= 1'b1;
      state <= IDLE;
      cnt <= '0;
      sr <= '0;
      addr_h <= '0;
      ptr <= '0;
      wrote <= 1'b0;
      busy <= 1'b0;
      twr <= '0;
      sda_oe <= 1'b0;
      dbg_data <= '0;
    end else begin
      scl_sy <= {scl_sy[0], scl_i};
      sda_sy <= {sda_sy[0], sda_i};
      scl_q <= scl_sy[1];
      sda_q <= sda_sy[1];
      dbg_data <= ~mem_n[dbg_addr];
      if (busy) begin
        busy <= twr != '0;
        twr <= twr - 32'd1;
      end
      if (start) begin
        state <= DEV_ADDR;
        cnt <= '0;
        sda_oe <= 1'b0;
        wrote <= 1'b0;
      end else if (stop) begin
        state <= IDLE;
        sda_oe <= 1'b0;
        wrote <= 1'b0;
        if (wrote && !busy && TWR_CYCLES > 0) begin
          busy <= 1'b1;
          twr <= 32'(TWR_CYCLES - 1);
        end
      end else if (scl_rise) begin
        case (state)
          DEV_ADDR, ADDR_H, ADDR_L, WR_DATA: begin
            sr <= rx_byte;
            cnt <= cnt + 4'd1;
            if (cnt == 4'd7) begin
              if (state == ADDR_H) addr_h <= rx_byte[2:0];
              if (state == ADDR_L) ptr <= {addr_h, rx_byte};
              if (state == WR_DATA) begin
                ptr[PW-1:0] <= ptr[PW-1:0] + PW'(1);
                wrote <= 1'b1;
              end
            end
          end
          RD_DATA: begin
            sr <= {sr[6:0], 1'b0};
            cnt <= cnt + 4'd1;
          end
          RD_ACK: begin
            state <= sda_sy[1] ? IDLE : RD_DATA;
            sr <= rd;
            cnt <= '0;
          end
          default: ;
        endcase
      end else if (scl_fall) begin
        case (state)
          DEV_ADDR:
            if (cnt == 4'd8) begin
              cnt <= '0;
              sda_oe <= dev_match;
              state <= dev_match ? ACK_DEV : IDLE;
            end
          ADDR_H, ADDR_L, WR_DATA:
            if (cnt == 4'd8) begin
              cnt <= '0;
              sda_oe <= 1'b1;
              state <= state == ADDR_H ? ACK_H : state == ADDR_L ? ACK_L : ACK_WR;
            end
          ACK_DEV: begin
            sda_oe <= sr[0] & ~rd[7];
            if (sr[0]) sr <= rd;
            state <= sr[0] ? RD_DATA : ADDR_H;
          end
          ACK_H: begin
            sda_oe <= 1'b0;
            state <= ADDR_L;
          end
          ACK_L, ACK_WR: begin
            sda_oe <= 1'b0;
            state <= WR_DATA;
          end
          RD_DATA: begin
            sda_oe <= cnt != 4'd8 && !sr[7];
            if (cnt == 4'd8) begin
              state <= RD_ACK;
              ptr <= ptr + 11'd1;
            end
          end
          default: ;
        endcase
      end
    end
endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// tb_i2c_eeprom_slave: bus-level master driving the EEPROM slave, with a byte model and read scoreboard
module tb_i2c_eeprom_slave;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scl = 1'b1;
  logic        sda_m = 1'b1;
  logic [10:0] dbg_addr = '0;
  logic        sda_o, sda_oe, busy;
  logic [7:0]  dbg_data;
  wire         sda_bus = sda_m & ~sda_oe;
  int          nchk = 0;
  int          nerr = 0;
  int          q = 3;
  logic [7:0]  exp_q[$];
  logic [7:0]  mdl [2048];

  i2c_eeprom_slave #(.SLAVE_ADDR(7'h50), .PAGE_BYTES(16), .TWR_CYCLES(100)) dut (
    .clk(clk), .rst(rst), .scl_i(scl), .sda_i(sda_bus), .sda_o(sda_o), .sda_oe(sda_oe),
    .busy(busy), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_start;
    sda_m = 1'b1; tick(q);
    scl = 1'b1; tick(2 * q);
    sda_m = 1'b0; tick(2 * q);
    scl = 1'b0; tick(q);
  endtask

  task automatic bus_stop;
    sda_m = 1'b0; tick(q);
    scl = 1'b1; tick(2 * q);
    sda_m = 1'b1; tick(2 * q);
  endtask

  task automatic wbit(input logic b);
    sda_m = b; tick(q);
    scl = 1'b1; tick(2 * q);
    scl = 1'b0; tick(q);
  endtask

  task automatic rbit(output logic b);
    sda_m = 1'b1; tick(q);
    scl = 1'b1; tick(q);
    b = sda_bus; tick(q);
    scl = 1'b0; tick(q);
  endtask

  task automatic wbyte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) wbit(d[i]);
    rbit(b);
    ack = ~b;
  endtask

  task automatic rbyte(input logic mack, output logic [7:0] d);
    logic b;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      rbit(b);
      d = {d[6:0], b};
    end
    wbit(~mack);
  endtask

  task automatic dbg_rd(input logic [10:0] a, output logic [7:0] d);
    dbg_addr = a;
    tick(3);
    d = dbg_data;
  endtask

  task automatic wait_idle;
    int n = 0;
    while (busy && n < 300) begin
      tick(1);
      n++;
    end
    nchk++;
    if (busy !== 1'b0) begin
      nerr++;
      $display("FAIL wait_idle: busy=%b after %0d clk, required 0", busy, n);
    end
  endtask

  // Full write transaction of n (1..3) data bytes; every byte must be ACKed
  task automatic wr_txn(input logic [10:0] a, input logic [7:0] b0, b1, b2, input int n);
    logic [7:0] pkt [6];
    logic ack;
    pkt = '{8'hA0, {5'd0, a[10:8]}, a[7:0], b0, b1, b2};
    bus_start;
    for (int i = 0; i < 3 + n; i++) begin
      wbyte(pkt[i], ack);
      nchk++;
      if (ack !== 1'b1) begin
        nerr++;
        $display("FAIL wr_ack byte %0d of write at %h: ack=%b required 1", i, a, ack);
      end
      if (i >= 3) mdl[{a[10:4], a[3:0] + 4'(i - 3)}] = pkt[i];
    end
    bus_stop;
    wait_idle;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(4);
    nchk += 4;
    if (sda_oe !== 1'b0) begin nerr++; $display("FAIL reset_sda_oe: got %b required 0", sda_oe); end
    if (sda_o !== 1'b0) begin nerr++; $display("FAIL reset_sda_o: got %b required 0", sda_o); end
    if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy: got %b required 0", busy); end
    if (dbg_data !== 8'h00) begin nerr++; $display("FAIL reset_dbg_data: got %h required 00", dbg_data); end
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_write;
    logic [7:0] d;
    wr_txn(11'h123, 8'hA5, 8'h3C, 8'h00, 2);
    dbg_rd(11'h123, d);
    nchk++;
    if (d !== 8'hA5) begin nerr++; $display("FAIL write_123: got %h required a5", d); end
    dbg_rd(11'h124, d);
    nchk++;
    if (d !== 8'h3C) begin nerr++; $display("FAIL write_124: got %h required 3c", d); end
    dbg_rd(11'h125, d);
    nchk++;
    if (d !== 8'hFF) begin nerr++; $display("FAIL write_125_untouched: got %h required ff", d); end
  endtask

  task automatic test_page_wrap;
    logic [7:0] d;
    logic [10:0] addrs [4] = '{11'h00E, 11'h00F, 11'h000, 11'h010};
    logic [7:0] want [4] = '{8'h11, 8'h22, 8'h33, 8'hFF};
    wr_txn(11'h00E, 8'h11, 8'h22, 8'h33, 3);
    for (int i = 0; i < 4; i++) begin
      dbg_rd(addrs[i], d);
      nchk++;
      if (d !== want[i]) begin nerr++; $display("FAIL page_wrap mem[%h]: got %h required %h", addrs[i], d, want[i]); end
    end
  endtask

  task automatic test_random_read;
    logic [7:0] pkt [3] = '{8'hA0, 8'h01, 8'h23};
    logic [7:0] d, e;
    logic ack;
    bus_start;
    for (int i = 0; i < 3; i++) begin
      wbyte(pkt[i], ack);
      nchk++;
      if (ack !== 1'b1) begin nerr++; $display("FAIL rand_read_addr_ack %0d: got %b required 1", i, ack); end
    end
    bus_start;
    wbyte(8'hA1, ack);
    nchk++;
    if (ack !== 1'b1) begin nerr++; $display("FAIL rand_read_dev_ack: got %b required 1", ack); end
    exp_q.push_back(mdl[11'h123]);
    exp_q.push_back(mdl[11'h124]);
    rbyte(1'b1, d);
    e = exp_q.pop_front();
    nchk++;
    if (d !== e) begin nerr++; $display("FAIL rand_read_byte0: got %h required %h", d, e); end
    rbyte(1'b0, d);
    e = exp_q.pop_front();
    nchk++;
    if (d !== e) begin nerr++; $display("FAIL rand_read_byte1: got %h required %h", d, e); end
    tick(1);
    nchk++;
    if (sda_oe !== 1'b0) begin nerr++; $display("FAIL rand_read_release: sda_oe=%b required 0", sda_oe); end
    bus_stop;
    // Current-address read shows where the pointer was left (0x125)
    bus_start;
    wbyte(8'hA1, ack);
    nchk++;
    if (ack !== 1'b1) begin nerr++; $display("FAIL cur_read_dev_ack: got %b required 1", ack); end
    exp_q.push_back(mdl[11'h125]);
    rbyte(1'b0, d);
    e = exp_q.pop_front();
    nchk++;
    if (d !== e) begin nerr++; $display("FAIL cur_read_ptr125: got %h required %h", d, e); end
    bus_stop;
  endtask

  task automatic test_read_wrap;
    logic [7:0] pkt [3] = '{8'hA0, 8'h07, 8'hFF};
    logic [7:0] d, e;
    logic ack;
    wr_txn(11'h7FF, 8'h5A, 8'h00, 8'h00, 1);
    bus_start;
    for (int i = 0; i < 3; i++) wbyte(pkt[i], ack);
    bus_start;
    wbyte(8'hA1, ack);
    nchk++;
    if (ack !== 1'b1) begin nerr++; $display("FAIL read_wrap_dev_ack: got %b required 1", ack); end
    exp_q.push_back(mdl[11'h7FF]);
    exp_q.push_back(mdl[11'h000]);
    rbyte(1'b1, d);
    e = exp_q.pop_front();
    nchk++;
    if (d !== e) begin nerr++; $display("FAIL read_wrap_7ff: got %h required %h", d, e); end
    rbyte(1'b0, d);
    e = exp_q.pop_front();
    nchk++;
    if (d !== e) begin nerr++; $display("FAIL read_wrap_000: got %h required %h", d, e); end
    bus_stop;
  endtask

  task automatic test_mismatch;
    logic [7:0] pkt [4] = '{8'hA2, 8'h01, 8'h23, 8'h77};
    logic [7:0] d;
    logic ack;
    bus_start;
    for (int i = 0; i < 4; i++) begin
      wbyte(pkt[i], ack);
      nchk++;
      if (ack !== 1'b0) begin nerr++; $display("FAIL mismatch_nack byte %0d: ack=%b required 0", i, ack); end
    end
    bus_stop;
    nchk++;
    if (busy !== 1'b0) begin nerr++; $display("FAIL mismatch_busy: got %b required 0", busy); end
    dbg_rd(11'h123, d);
    nchk++;
    if (d !== mdl[11'h123]) begin nerr++; $display("FAIL mismatch_mem: got %h required %h", d, mdl[11'h123]); end
  endtask

  task automatic test_busy;
    logic [7:0] pkt [4];
    logic [7:0] d;
    logic ack;
    int n;
    q = 2;
    for (int t = 0; t < 2; t++) begin
      pkt = '{8'hA0, 8'h00, 8'h40 + 8'(t), 8'h99 - 8'(t)};
      bus_start;
      for (int i = 0; i < 4; i++) begin
        wbyte(pkt[i], ack);
        nchk++;
        if (ack !== 1'b1) begin nerr++; $display("FAIL busy_wr_ack txn %0d byte %0d: got %b required 1", t, i, ack); end
      end
      mdl[11'h040 + 11'(t)] = pkt[3];
      sda_m = 1'b0; tick(q);
      scl = 1'b1; tick(2 * q);
      sda_m = 1'b1;
      if (t == 0) begin
        n = 0;
        while (!busy && n < 20) begin tick(1); n++; end
        n = 0;
        while (busy && n < 300) begin tick(1); n++; end
        nchk++;
        if (n !== 100) begin nerr++; $display("FAIL busy_length: got %0d clk required 100", n); end
      end
    end
    // ACK polling: the device address is refused until the write cycle ends
    bus_start;
    wbyte(8'hA0, ack);
    nchk++;
    if (ack !== 1'b0) begin nerr++; $display("FAIL busy_poll_nack: ack=%b required 0", ack); end
    nchk++;
    if (busy !== 1'b1) begin nerr++; $display("FAIL busy_during_poll: got %b required 1", busy); end
    bus_stop;
    wait_idle;
    bus_start;
    wbyte(8'hA0, ack);
    nchk++;
    if (ack !== 1'b1) begin nerr++; $display("FAIL busy_poll_ack: ack=%b required 1", ack); end
    bus_stop;
    tick(4);
    nchk++;
    if (busy !== 1'b0) begin nerr++; $display("FAIL busy_no_data_stop: got %b required 0", busy); end
    dbg_rd(11'h041, d);
    nchk++;
    if (d !== mdl[11'h041]) begin nerr++; $display("FAIL busy_mem_041: got %h required %h", d, mdl[11'h041]); end
    q = 3;
  endtask

  task automatic test_reset_mid_read;
    logic [7:0] d, e;
    logic ack;
    bus_start;
    for (int i = 7; i >= 0; i--) wbit(1'(8'hA1 >> i));
    tick(1);
    nchk++;
    if (sda_oe !== 1'b1) begin nerr++; $display("FAIL mid_read_ack_drive: sda_oe=%b required 1", sda_oe); end
    rst = 1'b1;
    tick(1);
    nchk++;
    if (sda_oe !== 1'b0) begin nerr++; $display("FAIL mid_read_reset_release: sda_oe=%b required 0", sda_oe); end
    rst = 1'b0;
    tick(2);
    bus_stop;
    // Pointer returns to 0 after reset
    bus_start;
    wbyte(8'hA1, ack);
    nchk++;
    if (ack !== 1'b1) begin nerr++; $display("FAIL post_reset_dev_ack: got %b required 1", ack); end
    exp_q.push_back(mdl[11'h000]);
    rbyte(1'b0, d);
    e = exp_q.pop_front();
    nchk++;
    if (d !== e) begin nerr++; $display("FAIL post_reset_ptr0: got %h required %h", d, e); end
    bus_stop;
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mdl[i] = 8'hFF;
    test_reset;
    test_write;
    test_page_wrap;
    test_random_read;
    test_read_wrap;
    test_mismatch;
    test_busy;
    test_reset_mid_read;
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
